// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin stream arbiter.
package arb_pkg;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam int ARB_N = 4;
    localparam int PTR_W = 2;

    // Rotate req so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [ARB_N-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [2*ARB_N-1:0] dbl;
        logic [ARB_N-1:0]   rot;
        logic [PTR_W-1:0]   idx;
        dbl = {req, req};
        rot = dbl[ptr +: ARB_N];
        idx = '0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (rot[i]) idx = PTR_W'(i);
        end
        return idx + ptr;
    endfunction

endpackage

// File: rtl/mux_4x_nbit.sv
// Plain 4:1 bus multiplexer, BUS_WIDTH bits wide.
module mux_4x_nbit #(
    parameter int BUS_WIDTH = 8
) (
    input  logic [1:0]           sel,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [BUS_WIDTH-1:0] c,
    input  logic [BUS_WIDTH-1:0] d,
    output logic [BUS_WIDTH-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/rr_arb_4x_nbit.sv
// Round-robin arbiter over four requesters feeding a one-entry registered
// output stage with a valid/ready handshake.
module rr_arb_4x_nbit
    import arb_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ARB_N-1:0]     req,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [BUS_WIDTH-1:0] c,
    input  logic [BUS_WIDTH-1:0] d,
    output logic [ARB_N-1:0]     gnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic [PTR_W-1:0]     out_src
);

    state_t               state;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     winner;
    logic [BUS_WIDTH-1:0] mux_y;
    logic                 load;
    logic                 take;

    assign winner    = rr_pick(req, ptr);
    assign out_valid = (state == FULL);
    assign load      = (state == EMPTY) || (out_ready && out_valid);
    // Gate with rst_n so no requester believes its word was taken while in reset.
    assign take      = load && (|req) && rst_n;

    always_comb begin
        gnt = '0;
        if (take) gnt[winner] = 1'b1;
    end

    mux_4x_nbit #(
        .BUS_WIDTH(BUS_WIDTH)
    ) u_mux (
        .sel(winner),
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .y  (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ptr      <= '0;
            out_data <= '0;
            out_src  <= '0;
        end else if (take) begin
            state    <= FULL;
            out_data <= mux_y;
            out_src  <= winner;
            ptr      <= winner + PTR_W'(1);
        end else if (load) begin
            state    <= EMPTY;
        end
    end

endmodule
